// File: rtl/ay_pkg.sv
// Shared types, register indices and write masks for the AY-3-8910 bus interface.
package ay_pkg;

  typedef enum logic [1:0] {AY_IDLE, AY_ADDR, AY_WRITE, AY_READ} ay_cmd_e;

  localparam logic [3:0] R_MIXER     = 4'd7;
  localparam logic [3:0] R_ENV_SHAPE = 4'd13;
  localparam logic [3:0] R_IOA       = 4'd14;

  // Bits the real chip does not implement read back as zero.
  function automatic logic [7:0] ay_mask(input logic [3:0] idx);
    logic [7:0] m;
    m = 8'hFF;
    case (idx)
      4'd1, 4'd3, 4'd5, 4'd13:  m = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10:  m = 8'h1F;
      default:                  m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ay_cmd_sync.sv
// Synchronizes the asynchronous decoder pseudo-commands and accepts a code only after it is stable.
// Multi-hot codes decode as idle and raise a sticky error.
module ay_cmd_sync
  import ay_pkg::*;
#(
  parameter int FILT = 2
) (
  input  logic       clk,
  input  logic       nRESET,
  input  logic [3:0] code_raw,
  output ay_cmd_e    cmd,
  output logic       cmd_vld,
  output logic       err
);

  localparam logic [2:0] FILT_N = 3'(FILT);

  logic [3:0] sync1, sync2, cand;
  logic [2:0] cnt, run_len;

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      sync1 <= '0;
      sync2 <= '0;
      cand  <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      sync1 <= code_raw;
      sync2 <= sync1;
      cand  <= sync2;
      cnt   <= run_len;
      if (cmd_vld && ($countones(sync2) > 1))
        err <= 1'b1;
    end
  end

  // run_len counts the current sample, so acceptance lands FILT edges after the code reaches sync2.
  always_comb begin
    run_len = 3'd1;
    if (sync2 == cand)
      run_len = (cnt == 3'd7) ? 3'd7 : cnt + 3'd1;
    cmd_vld = (run_len >= FILT_N);
    cmd = AY_IDLE;
    case (sync2)
      4'b0010: cmd = AY_ADDR;
      4'b0100: cmd = AY_WRITE;
      4'b1000: cmd = AY_READ;
      default: cmd = AY_IDLE;
    endcase
  end

endmodule

// File: rtl/ay_psg_bus_if.sv
// AY-3-8910 bus side: address latch with chip select, masked register file, read-back and port A.
// Writes commit on the trailing edge of WRPSG, matching the original chip.
module ay_psg_bus_if
  import ay_pkg::*;
#(
  parameter logic [3:0] CHIP_HI = 4'h0,
  parameter int         FILT    = 2
) (
  input  logic       clk,
  input  logic       nRESET,
  input  logic       ay_inact,
  input  logic       ay_laddr,
  input  logic       ay_wrpsg,
  input  logic       ay_rdpsg,
  input  logic [7:0] din,
  output logic [7:0] dq,
  output logic       dq_oe,
  input  logic [3:0] gen_sel,
  output logic [7:0] gen_val,
  output logic       env_restart,
  output logic       wr_evt,
  input  logic [7:0] ioa_in,
  output logic [7:0] ioa_out,
  output logic       ioa_dir,
  output logic       cmd_err
);

  ay_cmd_e    state_q, state_n, acc_cmd;
  logic       acc_vld, commit, sel_q;
  logic [3:0] addr_q;
  logic [7:0] wbuf_q, rd_dat;
  logic [7:0] regs [16];

  ay_cmd_sync #(.FILT(FILT)) u_sync (
    .clk      (clk),
    .nRESET   (nRESET),
    .code_raw ({ay_rdpsg, ay_wrpsg, ay_laddr, ay_inact}),
    .cmd      (acc_cmd),
    .cmd_vld  (acc_vld),
    .err      (cmd_err)
  );

  always_ff @(posedge clk) begin
    if (!nRESET) state_q <= AY_IDLE;
    else         state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    if (acc_vld)
      state_n = acc_cmd;
    commit = (state_q == AY_WRITE) && (state_n != AY_WRITE) && sel_q;
    dq_oe  = (state_q == AY_READ) && sel_q;
    rd_dat = regs[addr_q] & ay_mask(addr_q);
    if ((addr_q == R_IOA) && !regs[R_MIXER][6])
      rd_dat = ioa_in;
  end

  // addr_q on the right-hand side is still the pre-edge value, so WRITE->ADDR commits to the old address.
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      addr_q      <= '0;
      sel_q       <= 1'b1;
      wbuf_q      <= '0;
      dq          <= '0;
      wr_evt      <= 1'b0;
      env_restart <= 1'b0;
      for (int i = 0; i < 16; i++)
        regs[i] <= '0;
    end else begin
      wr_evt      <= commit;
      env_restart <= commit && (addr_q == R_ENV_SHAPE);
      if (commit)
        regs[addr_q] <= wbuf_q & ay_mask(addr_q);
      if (state_n == AY_ADDR) begin
        if (din[7:4] == CHIP_HI) begin
          sel_q  <= 1'b1;
          addr_q <= din[3:0];
        end else begin
          sel_q  <= 1'b0;
        end
      end
      if (state_n == AY_WRITE)
        wbuf_q <= din;
      if (state_q == AY_READ)
        dq <= rd_dat;
    end
  end

  assign gen_val = regs[gen_sel] & ay_mask(gen_sel);
  assign ioa_out = regs[R_IOA];
  assign ioa_dir = regs[R_MIXER][6];

endmodule
